// File: rtl/ro_worker_pkg.sv
// Shared definitions for the ring-oscillator worker: run-mode encodings and
// a byte-count helper.
package ro_worker_pkg;

  localparam logic [1:0] MODE_COUNT_TO = 2'd0;
  localparam logic [1:0] MODE_FREE     = 2'd1;
  localparam logic [1:0] MODE_BOUNDED  = 2'd2;
  localparam logic [1:0] MODE_RSVD     = 2'd3;

  function automatic int nbytes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ro_worker_core_if.sv
// Byte-serial load/readout and status bundle between the host side and the
// ring-oscillator worker core.
interface ro_worker_core_if;

  logic       shift_in;
  logic       stop_in;
  logic [1:0] mode;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy;
  logic       done;
  logic       ovf;

  modport master (
    output shift_in, stop_in, mode, din,
    input  dout, busy, done, ovf
  );

  modport slave (
    input  shift_in, stop_in, mode, din,
    output dout, busy, done, ovf
  );

endinterface

// File: rtl/ro_worker_core_sync_edge_detect.sv
// Multi-flop synchroniser followed by a registered rising-edge detector;
// rise is a one-cycle pulse STAGES+1 cycles after src rises.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  output logic rise
);

  logic [STAGES-1:0] sync_r;
  logic              hist_r;

  // Synchronise src, keep one history bit and register the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
      hist_r <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], src};
      hist_r <= sync_r[STAGES-1];
      rise   <= sync_r[STAGES-1] & ~hist_r;
    end
  end

endmodule

// File: rtl/ro_worker_core.sv
// Ring-oscillator worker: byte-serial operand load, counter-pair run until a
// mode-dependent stop, byte-serial readout. Optional wrap flag: RO_WORKER_OVF_EN.
module ro_worker_core
  import ro_worker_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  ro_worker_core_if.slave   bus
);

  localparam int NB    = nbytes(WIDTH);
  localparam int CNT_W = $clog2(2 * NB);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * NB - 1);

  logic [WIDTH-1:0]   da_r, db_r, ca_r, cb_r;
  logic [CNT_W-1:0]   byte_cnt_r;
  logic               busy_r, done_r;
  logic [1:0]         run_mode_r;

  logic               shift_rise_s, stop_rise_s;
  logic [2*WIDTH-1:0] ops_s, rot_s;
  logic [WIDTH-1:0]   sum_s;
  logic               stop_s, start_s;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_shift_edge (
    .clk  (clk),
    .rst  (rst),
    .src  (bus.shift_in),
    .rise (shift_rise_s)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_stop_edge (
    .clk  (clk),
    .rst  (rst),
    .src  (bus.stop_in),
    .rise (stop_rise_s)
  );

  // Next operand pair, counter rotation and start value for this shift edge.
  always_comb begin
    ops_s      = {da_r, db_r} << 4'd8;
    ops_s[7:0] = bus.din;
    rot_s      = {ca_r, cb_r} << 4'd8;
    rot_s[7:0] = ca_r[WIDTH-1 -: 8];
    sum_s      = ops_s[2*WIDTH-1:WIDTH] + ops_s[WIDTH-1:0];
    start_s    = !busy_r && shift_rise_s && (byte_cnt_r == LAST);
  end

  // Stop condition for the mode latched at start; mode 3 counts like mode 0.
  always_comb begin
    stop_s = 1'b0;
    case (run_mode_r)
      MODE_COUNT_TO: stop_s = (cb_r == db_r);
      MODE_FREE:     stop_s = stop_rise_s;
      MODE_BOUNDED:  stop_s = (cb_r == db_r) || stop_rise_s;
      MODE_RSVD:     stop_s = (cb_r == db_r);
      default:       stop_s = (cb_r == db_r);
    endcase
  end

  // Loader, start sequencing and run counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      da_r       <= '0;
      db_r       <= '0;
      ca_r       <= '0;
      cb_r       <= '0;
      byte_cnt_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      run_mode_r <= MODE_COUNT_TO;
    end else if (busy_r) begin
      if (stop_s) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        ca_r <= ca_r + 1'b1;
        cb_r <= cb_r + 1'b1;
      end
    end else if (shift_rise_s) begin
      da_r <= ops_s[2*WIDTH-1:WIDTH];
      db_r <= ops_s[WIDTH-1:0];
      if (start_s) begin
        byte_cnt_r <= '0;
        busy_r     <= 1'b1;
        done_r     <= 1'b0;
        cb_r       <= '0;
        ca_r       <= (bus.mode == MODE_FREE) ? sum_s : ops_s[2*WIDTH-1:WIDTH];
        run_mode_r <= bus.mode;
      end else begin
        ca_r       <= rot_s[2*WIDTH-1:WIDTH];
        cb_r       <= rot_s[WIDTH-1:0];
        byte_cnt_r <= byte_cnt_r + 1'b1;
      end
    end
  end

`ifdef RO_WORKER_OVF_EN
  logic ovf_r;

  // Sticky flag: a running increment carried ca from all-ones to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (start_s) begin
      ovf_r <= 1'b0;
    end else if (busy_r && !stop_s && (&ca_r)) begin
      ovf_r <= 1'b1;
    end
  end

  assign bus.ovf = ovf_r;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.dout = ca_r[WIDTH-1 -: 8];
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule
